// File: rtl/l2_writeback_buffer.sv
// Write-back (victim) buffer between the L2 cache and pmem: absorbs evictions, drains when idle.
// Build with L2_WB_FWD_EN defined to serve read hits from the buffer instead of draining first.
module l2_writeback_buffer #(
    parameter int unsigned LINE_W   = 256,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned OFFSET_W = 5,
    parameter int unsigned DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic [LINE_W-1:0] mem_wdata,
    output logic [LINE_W-1:0] mem_rdata,
    output logic              mem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);
    localparam int unsigned TAG_W = ADDR_W - OFFSET_W;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StRdPmem, StWbPmem, StResp} state_e;

    state_e            state_q;
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [LINE_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;

    logic [TAG_W-1:0]  req_tag;
    logic              hit;
    logic [PTR_W-1:0]  hit_idx;
    logic              full;
    logic              do_coalesce, do_push, do_drain, do_read, do_fwd;
    logic              unused_offset;

    assign req_tag       = mem_address[ADDR_W-1:OFFSET_W];
    assign full          = (count_q == CNT_W'(DEPTH));
    assign unused_offset = ^mem_address[OFFSET_W-1:0];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Coalescing keeps line addresses unique, so at most one entry can hit.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (tag_q[i] == req_tag)) begin
                hit     = 1'b1;
                hit_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        do_coalesce = 1'b0;
        do_push     = 1'b0;
        do_drain    = 1'b0;
        do_read     = 1'b0;
        do_fwd      = 1'b0;
        if (state_q == StIdle) begin
            if (mem_write) begin
                if (hit) do_coalesce = 1'b1;
                else if (!full) do_push = 1'b1;
                else do_drain = 1'b1;
            end else if (mem_read) begin
`ifdef L2_WB_FWD_EN
                if (hit) do_fwd = 1'b1;
                else do_read = 1'b1;
`else
                // Without a data forward path, empty the buffer so pmem is never stale.
                if (count_q != '0) do_drain = 1'b1;
                else do_read = 1'b1;
`endif
            end else if (count_q != '0) begin
                do_drain = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            mem_rdata    <= '0;
            mem_resp     <= 1'b0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            valid_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (do_coalesce) begin
                        data_q[hit_idx] <= mem_wdata;
                        mem_resp        <= 1'b1;
                        state_q         <= StResp;
                    end else if (do_push) begin
                        tag_q[tail_q]   <= req_tag;
                        data_q[tail_q]  <= mem_wdata;
                        valid_q[tail_q] <= 1'b1;
                        tail_q          <= ptr_inc(tail_q);
                        count_q         <= count_q + 1'b1;
                        mem_resp        <= 1'b1;
                        state_q         <= StResp;
                    end else if (do_fwd) begin
                        mem_rdata <= data_q[hit_idx];
                        mem_resp  <= 1'b1;
                        state_q   <= StResp;
                    end else if (do_read) begin
                        pmem_read    <= 1'b1;
                        pmem_address <= {req_tag, {OFFSET_W{1'b0}}};
                        state_q      <= StRdPmem;
                    end else if (do_drain) begin
                        pmem_write   <= 1'b1;
                        pmem_address <= {tag_q[head_q], {OFFSET_W{1'b0}}};
                        pmem_wdata   <= data_q[head_q];
                        state_q      <= StWbPmem;
                    end
                end
                StRdPmem: begin
                    if (pmem_resp) begin
                        pmem_read <= 1'b0;
                        mem_rdata <= pmem_rdata;
                        mem_resp  <= 1'b1;
                        state_q   <= StResp;
                    end
                end
                StWbPmem: begin
                    if (pmem_resp) begin
                        pmem_write      <= 1'b0;
                        valid_q[head_q] <= 1'b0;
                        head_q          <= ptr_inc(head_q);
                        count_q         <= count_q - 1'b1;
                        state_q         <= StIdle;
                    end
                end
                StResp: begin
                    mem_resp <= 1'b0;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Simultaneous read and write from L2 is a protocol error; the write is served.
    assert property (@(posedge clk) disable iff (!rst_n) !(mem_read && mem_write));

endmodule

// File: tb/tb_l2_writeback_buffer.sv
// Bench for l2_writeback_buffer: acts as L2 and pmem, checks against a buffer-over-memory model.
`timescale 1ns/1ps
module tb_l2_writeback_buffer;
    localparam int LINE_W = 256;
    localparam int ADDR_W = 16;
    localparam int OFFSET_W = 5;
    localparam int DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              mem_read = 1'b0;
    logic              mem_write = 1'b0;
    logic [ADDR_W-1:0] mem_address = '0;
    logic [LINE_W-1:0] mem_wdata = '0;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata = '0;
    logic              pmem_resp = 1'b0;

    always #5 clk = ~clk;

    l2_writeback_buffer #(
        .LINE_W  (LINE_W),
        .ADDR_W  (ADDR_W),
        .OFFSET_W(OFFSET_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_resp    (mem_resp),
        .pmem_read   (pmem_read),
        .pmem_write  (pmem_write),
        .pmem_address(pmem_address),
        .pmem_wdata  (pmem_wdata),
        .pmem_rdata  (pmem_rdata),
        .pmem_resp   (pmem_resp)
    );

    typedef struct { logic [10:0] line; logic [255:0] data; } entry_t;
    typedef struct { bit is_rd; logic [15:0] addr; logic [255:0] data; } op_t;

    entry_t       buf_q[$];
    op_t          ops[$];
    logic [255:0] pmem_mem [logic [10:0]];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit pm_busy = 0;
    int pm_wait = 0;
    int pm_lat = 1;
    int force_lat = 0;
    int resp_cyc = 0;
    int rd_start_cyc = 0;
    int last_resp_cyc = 0;
    logic [10:0] cur_line = '0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] init_line(input logic [10:0] line);
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = {line, 5'(i), 16'hA5C3} ^ 32'h1234_5678;
        return v;
    endfunction

    function automatic logic [255:0] pmem_val(input logic [10:0] line);
        return pmem_mem.exists(line) ? pmem_mem[line] : init_line(line);
    endfunction

    function automatic int buf_find(input logic [10:0] line);
        for (int i = 0; i < buf_q.size(); i++) if (buf_q[i].line == line) return i;
        return -1;
    endfunction

    // What L2 should read back: a buffered line shadows pmem.
    function automatic logic [255:0] l2_view(input logic [10:0] line);
        int idx;
        idx = buf_find(line);
        return (idx >= 0) ? buf_q[idx].data : pmem_val(line);
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // One clock; also plays the pmem side.
    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (pmem_resp) begin
            pmem_resp = 1'b0;
            pm_busy = 1'b0;
            check("pmem_req_drop", {pmem_read, pmem_write}, 0);
        end else if (pmem_read || pmem_write) begin
            if (!pm_busy) begin
                pm_busy = 1'b1;
                pm_wait = 0;
                pm_lat = (force_lat > 0) ? force_lat : int'($urandom_range(1, 4));
                check("pmem_rd_wr_excl", pmem_read && pmem_write, 0);
                if (pmem_write) begin
                    ops.push_back('{is_rd: 1'b0, addr: pmem_address, data: pmem_wdata});
                    check("drain_nonempty", buf_q.size() != 0, 1);
                    if (buf_q.size() != 0) begin
                        check("drain_addr", pmem_address, {buf_q[0].line, 5'b0});
                        check("drain_data", pmem_wdata, buf_q[0].data);
                        pmem_mem[buf_q[0].line] = buf_q[0].data;
                        void'(buf_q.pop_front());
                    end
                end else begin
                    ops.push_back('{is_rd: 1'b1, addr: pmem_address, data: '0});
                    rd_start_cyc = cyc;
                    check("rd_addr", pmem_address, {cur_line, 5'b0});
`ifdef L2_WB_FWD_EN
                    check("rd_miss_only", buf_find(cur_line) >= 0, 0);
`else
                    check("rd_after_drain", buf_q.size(), 0);
`endif
                end
            end
            pm_wait++;
            if (pm_wait >= pm_lat) begin
                pmem_resp = 1'b1;
                resp_cyc = cyc;
                if (pmem_read) pmem_rdata = pmem_val(pmem_address[15:5]);
            end
        end
    endtask

    task automatic l2_req(input bit wr, input logic [15:0] addr, input logic [255:0] data,
                          input int exp_lat, input string tag);
        int n;
        int idx;
        bit got;
        cur_line = addr[15:5];
        mem_read = !wr;
        mem_write = wr;
        mem_address = addr;
        mem_wdata = data;
        n = 0;
        got = 1'b0;
        while (!got && n < 300) begin
            cycle();
            n++;
            got = mem_resp;
        end
        mem_read = 1'b0;
        mem_write = 1'b0;
        check({tag, "_resp"}, got, 1);
        if (got) begin
            last_resp_cyc = cyc;
            if (exp_lat > 0) check({tag, "_lat"}, n, exp_lat);
            if (wr) begin
                idx = buf_find(addr[15:5]);
                if (idx >= 0) buf_q[idx].data = data;
                else buf_q.push_back('{line: addr[15:5], data: data});
            end else begin
                check({tag, "_rdata"}, mem_rdata, l2_view(addr[15:5]));
            end
        end
        cycle();
        check({tag, "_pulse"}, mem_resp, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic drain_all();
        int k;
        k = 0;
        while ((buf_q.size() != 0 || pm_busy) && k < 200) begin
            cycle();
            k++;
        end
        idle(3);
        check("drain_done", buf_q.size() != 0 || pm_busy, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mem_resp"}, mem_resp, 0);
        check({tag, "_mem_rdata"}, mem_rdata, 0);
        check({tag, "_pmem_rw"}, {pmem_read, pmem_write}, 0);
        check({tag, "_pmem_addr"}, pmem_address, 0);
        check({tag, "_pmem_wdata"}, pmem_wdata, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] d1, d2, d3, d4;
        int req_cyc;
        d1 = rand_line();
        d2 = rand_line();
        d3 = rand_line();
        d4 = rand_line();

        // Reset state
        #1 rst_n = 1'b0;
        idle(2);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        idle(2);

        // Single write, then drained while L2 is idle
        ops.delete();
        l2_req(1, 16'h1240, d1, 1, "wr_1240");
        drain_all();
        check("t1_ops", ops.size(), 1);
        if (ops.size() >= 1) begin
            check("t1_addr", ops[0].addr, 16'h1240);
            check("t1_data", ops[0].data, d1);
        end

        // Fill, then a write to a full buffer drains the head first
        ops.delete();
        force_lat = 2;
        l2_req(1, 16'h1000, rand_line(), 1, "wr_1000");
        l2_req(1, 16'h2000, rand_line(), 1, "wr_2000");
        l2_req(1, 16'h3000, rand_line(), 0, "wr_3000_full");
        check("t2_first_drain_cnt", ops.size(), 1);
        if (ops.size() >= 1) check("t2_first_drain", ops[0].addr, 16'h1000);
        force_lat = 0;
        drain_all();
        check("t2_ops", ops.size(), 3);
        if (ops.size() >= 3) begin
            check("t2_second", ops[1].addr, 16'h2000);
            check("t2_third", ops[2].addr, 16'h3000);
        end

        // Coalesce two writes to the same line
        ops.delete();
        l2_req(1, 16'h4000, d1, 1, "wr_4000");
        l2_req(1, 16'h4010, d2, 1, "wr_4010");
        drain_all();
        check("t3_ops", ops.size(), 1);
        if (ops.size() >= 1) begin
            check("t3_addr", ops[0].addr, 16'h4000);
            check("t3_data", ops[0].data, d2);
        end

        // Read of a buffered line
        ops.delete();
        l2_req(1, 16'h5000, d3, 1, "wr_5000");
`ifdef L2_WB_FWD_EN
        l2_req(0, 16'h5000, '0, 1, "rd_5000_fwd");
        check("t4_no_pmem", ops.size(), 0);
        check("t4_data", mem_rdata, d3);
        drain_all();
        check("t4_kept", ops.size(), 1);
        if (ops.size() >= 1) check("t4_kept_addr", ops[0].addr, 16'h5000);
`else
        l2_req(0, 16'h5000, '0, 0, "rd_5000");
        check("t4_data", mem_rdata, d3);
        check("t4_ops", ops.size(), 2);
        if (ops.size() >= 2) begin
            check("t4_op0_kind", ops[0].is_rd, 0);
            check("t4_op0_addr", ops[0].addr, 16'h5000);
            check("t4_op1_kind", ops[1].is_rd, 1);
            check("t4_op1_addr", ops[1].addr, 16'h5000);
        end
        drain_all();
`endif

        // Read miss with slow pmem
        ops.delete();
        pmem_mem[11'h300] = d4;
        force_lat = 7;
        req_cyc = cyc;
        l2_req(0, 16'h6000, '0, 0, "rd_6000");
        force_lat = 0;
        check("t5_data", mem_rdata, d4);
        check("t5_rd_start", rd_start_cyc - req_cyc, 1);
        check("t5_resp_after_pmem", last_resp_cyc - resp_cyc, 1);

        // Reset in the middle of a transaction drops request and buffered lines
        l2_req(1, 16'h7100, rand_line(), 1, "wr_7100");
        l2_req(1, 16'h7200, rand_line(), 1, "wr_7200");
        cur_line = 11'h380;
        force_lat = 20;
        mem_read = 1'b1;
        mem_address = 16'h7000;
        idle(3);
        check("t5_busy_before_rst", pmem_read | pmem_write, 1);
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        mem_read = 1'b0;
        pmem_resp = 1'b0;
        pm_busy = 1'b0;
        force_lat = 0;
        buf_q.delete();
        idle(2);
        rst_n = 1'b1;
        ops.delete();
        idle(8);
        check("t5_dropped", ops.size(), 0);

        // Randomized traffic over a small set of lines
        for (int t = 0; t < 200; t++) begin
            logic [15:0] a;
            a = 16'hA000 + 16'(($urandom_range(0, 5)) * 32) + 16'($urandom_range(0, 31));
            if ($urandom_range(0, 9) < 6) l2_req(1, a, rand_line(), 0, "rnd_wr");
            else l2_req(0, a, '0, 0, "rnd_rd");
            idle($urandom_range(0, 3));
        end
        drain_all();
        for (int k = 0; k < 6; k++) begin
            logic [10:0] ln;
            ln = 11'h500 + 11'(k);
            l2_req(0, {ln, 5'b0}, '0, 0, "final_rd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
